echo_indication_output: RTL and testbench
=========================================

# echo_indication_output

Indication-side portal adapter for the echo test. It accepts `heard(v)` method calls from the echo request path, directly downstream of the one-entry delay FIFO, and buffers each 32-bit payload as a one-word message in an indication FIFO. It exposes that FIFO to the host portal as indication pipe 0, together with the message-size lookup and the interrupt status/channel signals.

## Interface

Parameters:
- `DEPTH`, 4, number of indication words buffered; power of two, ≥2.

Ports:
- `CLK` in 1: single clock; all state on rising edge.
- `RST_N` in 1: reset, asynchronous assert, active-low.
- `ifc_heard_v` in 32: payload of `heard`.
- `EN_ifc_heard` in 1: enqueue strobe; only legal when `RDY_ifc_heard` is 1.
- `RDY_ifc_heard` out 1: FIFO not full.
- `portalIfc_messageSize_size_methodNumber` in 16: method number to look up.
- `portalIfc_messageSize_size` out 16: message size in bits for that method.
- `RDY_portalIfc_messageSize_size` out 1: constant 1.
- `portalIfc_indications_0_first` out 32: head word.
- `RDY_portalIfc_indications_0_first` out 1: FIFO not empty.
- `EN_portalIfc_indications_0_deq` in 1: dequeue strobe; only legal when `RDY_portalIfc_indications_0_deq` is 1.
- `RDY_portalIfc_indications_0_deq` out 1: FIFO not empty.
- `portalIfc_indications_0_notEmpty` out 1: FIFO not empty.
- `RDY_portalIfc_indications_0_notEmpty` out 1: constant 1.
- `portalIfc_intr_status` out 1: interrupt pending.
- `RDY_portalIfc_intr_status` out 1: constant 1.
- `portalIfc_intr_channel` out 32: lowest non-empty pipe, or all-ones.
- `RDY_portalIfc_intr_channel` out 1: constant 1.

## Operation

- Storage is a circular buffer of DEPTH×32 words.
  - Read pointer `rp` and write pointer `wp` are each log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy `cnt` is log2(DEPTH)+1 bits.
- Enqueue: when `EN_ifc_heard` is asserted and `cnt < DEPTH`, write `ifc_heard_v` to `mem[wp]`, increment `wp`, and increment `cnt`.
- Dequeue: when `EN_portalIfc_indications_0_deq` is asserted and `cnt != 0`, increment `rp` and decrement `cnt`.
- Simultaneous enqueue and dequeue, both legal: `cnt` is unchanged and both pointers advance.
  - Full and empty are never bypassed: no enqueue while full, even when a dequeue occurs in the same cycle.
  - Data written this cycle is never visible on `first` in the same cycle.
- An enable asserted while its RDY is 0 is ignored: no state change. The bench flags it as a protocol error.
- `first` is `mem[rp]` when `cnt != 0`, else 32'h0.
- Message size is purely combinational: method 0 (`heard`) gives 16'd32; any other value gives 16'd0.
- Interrupt signals:
  - `intr_status = notEmpty`.
  - `intr_channel` = 32'd0 when `notEmpty`, else 32'hFFFF_FFFF.
- Reset (`RST_N` low, asynchronous, at any time including mid-transfer):
  - `rp`, `wp` and `cnt` go to 0 and buffered words are discarded.
  - Memory contents are not reset.
- Reset values of outputs:
  - `RDY_ifc_heard` = 1.
  - `RDY_..._first`, `RDY_..._deq`, `notEmpty` and `intr_status` = 0.
  - `first` = 0.
  - `intr_channel` = FFFF_FFFF.
  - Constant RDYs = 1.
  - `messageSize_size` follows its input.

## Timing

- Enqueue-to-visible latency is 1 cycle: a word enqueued at edge N appears on `first` and `notEmpty` after edge N.
- Dequeue takes effect at the edge; the next word appears after that edge.
- All RDY/status outputs are decoded from registered `cnt`; none depend combinationally on any EN input.
- `messageSize_size` is the only combinational input-to-output path.
- Sustained throughput is one enqueue and one dequeue per cycle when 0 < `cnt` < DEPTH.

## Structure

- Package `echo_portal_pkg` holds:
  - `HEARD_METHOD` = 16'd0
  - `HEARD_SIZE_BITS` = 16'd32
  - `INTR_CHANNEL_NONE` = 32'hFFFF_FFFF
  - the 32-bit word typedef
- Sub-module `portal_word_fifo` (parameters DEPTH and width 32) contains the pointers, count, memory, and the enq/deq/first/full/empty logic. It is reused by later multi-pipe portals.
- The top level adds the size lookup, interrupt decode and RDY constants.

## Test plan

- Reset check: assert `RST_N` low, release → `RDY_ifc_heard`=1, `notEmpty`=0, `intr_status`=0, `intr_channel`=FFFF_FFFF, `first`=0.
- Single word: enqueue 32'hDEAD_BEEF → next cycle `first`=DEADBEEF and `intr_channel`=0; dequeue → `notEmpty`=0 and `intr_channel`=FFFF_FFFF.
- Full and wrap:
  - Enqueue 1,2,3,4 (DEPTH=4) → `RDY_ifc_heard`=0; an extra EN with value 5 is ignored.
  - Dequeue two, enqueue 6,7 → dequeue order 3,4,6,7.
- Simultaneous: with `cnt`=2, enqueue and dequeue on the same edge for 8 cycles with an incrementing payload → `cnt` stays 2 and the output sequence is in order with no loss.
- Size lookup: methodNumber 0 → 32; methodNumber 1 → 0; methodNumber 16'hFFFF → 0.
- Reset mid-stream: with 3 words queued, pulse `RST_N` low asynchronously between edges → outputs return to reset values immediately; the next enqueue of 32'h55 is the first word out.

Source files
------------

// File: rtl/echo_portal_pkg.sv
// Shared constants and types for the echo portal indication path.
package echo_portal_pkg;

    typedef logic [31:0] word_t;

    localparam logic [15:0] HEARD_METHOD      = 16'd0;
    localparam logic [15:0] HEARD_SIZE_BITS   = 16'd32;
    localparam word_t       INTR_CHANNEL_NONE = 32'hFFFF_FFFF;

    // Message size in bits for a given indication method number.
    function automatic logic [15:0] messageSizeOf(input logic [15:0] methodNumber);
        return (methodNumber == HEARD_METHOD) ? HEARD_SIZE_BITS : 16'd0;
    endfunction

endpackage

// File: rtl/portal_word_fifo.sv
// Circular-buffer word FIFO used as one indication pipe of a portal.
module portal_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             enqEn,
    input  logic [WIDTH-1:0] enqData,
    input  logic             deqEn,
    output logic [WIDTH-1:0] first,
    output logic             notFull,
    output logic             notEmpty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rp;
    logic [AW-1:0]    wp;
    logic [AW:0]      cnt;
    logic             doEnq;
    logic             doDeq;

    // Status comes only from the registered count, so enables never reach RDY.
    assign notFull  = (cnt != FULL_CNT);
    assign notEmpty = (cnt != '0);
    assign doEnq    = enqEn && notFull;
    assign doDeq    = deqEn && notEmpty;
    assign first    = notEmpty ? mem[rp] : '0;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            if (doEnq) wp <= wp + 1'b1;
            if (doDeq) rp <= rp + 1'b1;
            case ({doEnq, doDeq})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is left uninitialised across reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (doEnq) mem[wp] <= enqData;
    end

endmodule

// File: rtl/echo_indication_output.sv
// Indication-side portal adapter: buffers heard(v) payloads for host pipe 0.
module echo_indication_output
    import echo_portal_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] ifc_heard_v,
    input  logic        EN_ifc_heard,
    output logic        RDY_ifc_heard,
    input  logic [15:0] portalIfc_messageSize_size_methodNumber,
    output logic [15:0] portalIfc_messageSize_size,
    output logic        RDY_portalIfc_messageSize_size,
    output logic [31:0] portalIfc_indications_0_first,
    output logic        RDY_portalIfc_indications_0_first,
    input  logic        EN_portalIfc_indications_0_deq,
    output logic        RDY_portalIfc_indications_0_deq,
    output logic        portalIfc_indications_0_notEmpty,
    output logic        RDY_portalIfc_indications_0_notEmpty,
    output logic        portalIfc_intr_status,
    output logic        RDY_portalIfc_intr_status,
    output logic [31:0] portalIfc_intr_channel,
    output logic        RDY_portalIfc_intr_channel
);

    word_t pipeFirst;
    logic  pipeNotFull;
    logic  pipeNotEmpty;

    portal_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) pipe0 (
        .clk      (CLK),
        .rstN     (RST_N),
        .enqEn    (EN_ifc_heard),
        .enqData  (ifc_heard_v),
        .deqEn    (EN_portalIfc_indications_0_deq),
        .first    (pipeFirst),
        .notFull  (pipeNotFull),
        .notEmpty (pipeNotEmpty)
    );

    assign RDY_ifc_heard                        = pipeNotFull;
    assign portalIfc_indications_0_first        = pipeFirst;
    assign RDY_portalIfc_indications_0_first    = pipeNotEmpty;
    assign RDY_portalIfc_indications_0_deq      = pipeNotEmpty;
    assign portalIfc_indications_0_notEmpty     = pipeNotEmpty;
    assign RDY_portalIfc_indications_0_notEmpty = 1'b1;

    assign portalIfc_messageSize_size     = messageSizeOf(portalIfc_messageSize_size_methodNumber);
    assign RDY_portalIfc_messageSize_size = 1'b1;

    // Only one pipe exists, so the lowest non-empty channel is 0 or none.
    assign portalIfc_intr_status      = pipeNotEmpty;
    assign RDY_portalIfc_intr_status  = 1'b1;
    assign portalIfc_intr_channel     = pipeNotEmpty ? 32'd0 : INTR_CHANNEL_NONE;
    assign RDY_portalIfc_intr_channel = 1'b1;

endmodule

// File: tb/tb_echo_indication_output.sv
// Scoreboard bench for echo_indication_output with directed and random traffic.
module tb_echo_indication_output;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] ifc_heard_v = '0;
    logic        EN_ifc_heard = 1'b0;
    logic        RDY_ifc_heard;
    logic [15:0] methodNumber = '0;
    logic [15:0] messageSize;
    logic        RDY_messageSize;
    logic [31:0] first;
    logic        RDY_first;
    logic        EN_deq = 1'b0;
    logic        RDY_deq;
    logic        notEmpty;
    logic        RDY_notEmpty;
    logic        intrStatus;
    logic        RDY_intrStatus;
    logic [31:0] intrChannel;
    logic        RDY_intrChannel;

    echo_indication_output #(.DEPTH(DEPTH)) dut (
        .CLK                                     (CLK),
        .RST_N                                   (RST_N),
        .ifc_heard_v                             (ifc_heard_v),
        .EN_ifc_heard                            (EN_ifc_heard),
        .RDY_ifc_heard                           (RDY_ifc_heard),
        .portalIfc_messageSize_size_methodNumber (methodNumber),
        .portalIfc_messageSize_size              (messageSize),
        .RDY_portalIfc_messageSize_size          (RDY_messageSize),
        .portalIfc_indications_0_first           (first),
        .RDY_portalIfc_indications_0_first       (RDY_first),
        .EN_portalIfc_indications_0_deq          (EN_deq),
        .RDY_portalIfc_indications_0_deq         (RDY_deq),
        .portalIfc_indications_0_notEmpty        (notEmpty),
        .RDY_portalIfc_indications_0_notEmpty    (RDY_notEmpty),
        .portalIfc_intr_status                   (intrStatus),
        .RDY_portalIfc_intr_status               (RDY_intrStatus),
        .portalIfc_intr_channel                  (intrChannel),
        .RDY_portalIfc_intr_channel              (RDY_intrChannel)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    logic [31:0] expQ[$];    // scoreboard: words expected on dequeue, in order
    logic [31:0] modelQ[$];  // reference contents of the indication FIFO

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every output that follows from the queue contents, against the model.
    task automatic checkStatus(input string tag);
        logic ne;
        ne = (modelQ.size() != 0);
        chk({tag, ".notEmpty"}, 32'(notEmpty), 32'(ne));
        chk({tag, ".rdyFirst"}, 32'(RDY_first), 32'(ne));
        chk({tag, ".rdyDeq"}, 32'(RDY_deq), 32'(ne));
        chk({tag, ".rdyHeard"}, 32'(RDY_ifc_heard), 32'(modelQ.size() < DEPTH));
        chk({tag, ".intrStatus"}, 32'(intrStatus), 32'(ne));
        chk({tag, ".intrChannel"}, intrChannel, ne ? 32'd0 : 32'hFFFF_FFFF);
        chk({tag, ".first"}, first, ne ? modelQ[0] : 32'd0);
        chk({tag, ".constRdy"}, {28'd0, RDY_messageSize, RDY_notEmpty, RDY_intrStatus, RDY_intrChannel}, 32'hF);
    endtask

    // One clock cycle with the given enables; enables only count when legal.
    task automatic step(input logic enq, input logic [31:0] data, input logic deq, input string tag);
        logic legalEnq, legalDeq;
        legalEnq = enq && (modelQ.size() < DEPTH);
        legalDeq = deq && (modelQ.size() != 0);
        if (enq && !legalEnq) $display("protocol error: %s enq %h while not ready (expect ignored)", tag, data);
        if (deq && !legalDeq) $display("protocol error: %s deq while empty (expect ignored)", tag);
        EN_ifc_heard = enq;
        ifc_heard_v  = data;
        EN_deq       = deq;
        if (legalEnq) expQ.push_back(data);
        @(posedge CLK);
        if (legalDeq) void'(modelQ.pop_front());
        if (legalEnq) modelQ.push_back(data);
        #1;
        EN_ifc_heard = 1'b0;
        EN_deq       = 1'b0;
        $display("cycle %s: enq=%0b data=%h deq=%0b occupancy=%0d", tag, enq, data, deq, modelQ.size());
        checkStatus(tag);
    endtask

    // Monitor: whenever a dequeue is presented and accepted, the head must match.
    always @(negedge CLK) begin
        if (RST_N && EN_deq && RDY_deq) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL deqOrder: got %h expected no word queued", first);
            end else begin
                chk("deqOrder", first, expQ.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] payload;
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b1;
        #1 checkStatus("reset");

        // single word
        step(1'b1, 32'hDEAD_BEEF, 1'b0, "single.enq");
        step(1'b0, 32'h0, 1'b1, "single.deq");

        // fill, overflow attempt, wrap
        for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0, "fill");
        step(1'b1, 32'd5, 1'b0, "overfull");
        step(1'b0, 32'h0, 1'b1, "drain");
        step(1'b0, 32'h0, 1'b1, "drain");
        step(1'b1, 32'd6, 1'b0, "wrap");
        step(1'b1, 32'd7, 1'b0, "wrap");
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, "wrapdrain");

        // simultaneous enqueue/dequeue at occupancy 2
        step(1'b1, 32'h100, 1'b0, "simpre");
        step(1'b1, 32'h101, 1'b0, "simpre");
        for (int i = 0; i < 8; i++) step(1'b1, 32'h102 + 32'(i), 1'b1, "sim");
        chk("sim.occupancy", 32'(modelQ.size()), 32'd2);
        step(1'b0, 32'h0, 1'b1, "simdrain");
        step(1'b0, 32'h0, 1'b1, "simdrain");

        // message-size lookup
        methodNumber = 16'd0;
        #1 chk("size.m0", 32'(messageSize), 32'd32);
        methodNumber = 16'd1;
        #1 chk("size.m1", 32'(messageSize), 32'd0);
        methodNumber = 16'hFFFF;
        #1 chk("size.mFFFF", 32'(messageSize), 32'd0);

        // asynchronous reset with three words queued
        for (int i = 0; i < 3; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, "prereset");
        #2 RST_N = 1'b0;
        #1;
        expQ.delete();
        modelQ.delete();
        $display("async reset asserted mid-stream");
        checkStatus("midreset");
        @(negedge CLK);
        RST_N = 1'b1;
        #1 checkStatus("postreset");
        step(1'b1, 32'h55, 1'b0, "after.enq");
        step(1'b0, 32'h0, 1'b1, "after.deq");

        // random legal traffic, with occasional illegal enables
        for (int i = 0; i < 300; i++) begin
            logic e, d;
            payload = $urandom;
            e = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) != 0) begin
                if (modelQ.size() >= DEPTH) e = 1'b0;
                if (modelQ.size() == 0) d = 1'b0;
            end
            step(e, payload, d, "rand");
        end
        while (modelQ.size() != 0) step(1'b0, 32'h0, 1'b1, "final");
        chk("final.scoreboardEmpty", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
